// File: rtl/kirsch_pkg.sv
// Shared types and constants for the sequential Kirsch compass operator.
package kirsch_pkg;

  localparam int unsigned PIX_W_DEF = 8;

  localparam int unsigned W_POS = 5;
  localparam int unsigned W_NEG = 3;

  typedef enum logic [2:0] {
    DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Ring position (clockwise from top-left) -> slot in the raster-ordered
  // pixel vector {p1,p2,p3,p4,p6,p7,p8,p9} (slot 0 = p1).
  localparam logic [2:0] RING_SLOT [8] = '{3'd0, 3'd1, 3'd2, 3'd4,
                                           3'd7, 3'd6, 3'd5, 3'd3};

endpackage

// File: rtl/kirsch_dir_unit.sv
// Single Kirsch compass direction: ring mux, weighted sums, clamp to PIX_W.
module kirsch_dir_unit
  import kirsch_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF
) (
  input  logic [7:0][PIX_W-1:0] i_pix,
  input  dir_e                  i_dir,
  output logic [PIX_W-1:0]      o_mag
);

  logic [PIX_W+1:0] w_sum_pos;
  logic [PIX_W+2:0] w_sum_neg;
  logic [PIX_W+4:0] w_r;

  // Split the ring into the three +5 pixels and the five -3 pixels.
  always_comb begin
    logic [2:0] rel;
    w_sum_pos = '0;
    w_sum_neg = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      rel = 3'(i) - i_dir;
      if (rel < 3'd3)
        w_sum_pos = w_sum_pos + (PIX_W+2)'(i_pix[RING_SLOT[i]]);
      else
        w_sum_neg = w_sum_neg + (PIX_W+3)'(i_pix[RING_SLOT[i]]);
    end
  end

  // 5A - 3B in two's complement, then clamp to [0, 2^PIX_W-1].
  always_comb begin
    w_r = (PIX_W+5)'(w_sum_pos) * (PIX_W+5)'(W_POS)
        - (PIX_W+5)'(w_sum_neg) * (PIX_W+5)'(W_NEG);
    if (w_r[PIX_W+4])
      o_mag = '0;
    else if (w_r[PIX_W+3:PIX_W] != '0)
      o_mag = '1;
    else
      o_mag = w_r[PIX_W-1:0];
  end

endmodule

// File: rtl/kirsch_compass_seq.sv
// Time-multiplexed Kirsch compass: one direction per clock, running maximum.
module kirsch_compass_seq
  import kirsch_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] p1,
  input  logic [PIX_W-1:0] p2,
  input  logic [PIX_W-1:0] p3,
  input  logic [PIX_W-1:0] p4,
  input  logic [PIX_W-1:0] p6,
  input  logic [PIX_W-1:0] p7,
  input  logic [PIX_W-1:0] p8,
  input  logic [PIX_W-1:0] p9,
  input  logic [7:0]       cfg_dir_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_mag,
  output logic [2:0]       out_dir,
  output logic             busy
);

  localparam logic [3:0] CNT_LAST = 4'd8;

  state_e                r_state, w_state_nxt;
  logic [7:0][PIX_W-1:0] r_pix;
  logic [7:0]            r_mask;
  logic [3:0]            r_cnt;
  logic [PIX_W-1:0]      r_cand_mag;
  logic [2:0]            r_cand_dir;
  logic                  r_cand_vld;
  logic [PIX_W-1:0]      r_best_mag;
  logic [2:0]            r_best_dir;
  logic [PIX_W-1:0]      r_out_mag;
  logic [2:0]            r_out_dir;

  logic [PIX_W-1:0]      w_dir_mag;
  logic                  w_accept;
  logic                  w_take;
  logic [PIX_W-1:0]      w_best_mag;
  logic [2:0]            w_best_dir;

  kirsch_dir_unit #(.PIX_W(PIX_W)) u_dir (
    .i_pix (r_pix),
    .i_dir (dir_e'(r_cnt[2:0])),
    .o_mag (w_dir_mag)
  );

  // Handshake decode and max-tracker merge of the registered candidate.
  always_comb begin
    in_ready   = rst_n && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
    w_accept   = in_ready && in_valid;
    out_valid  = (r_state == ST_DONE);
    busy       = (r_state == ST_RUN);
    out_mag    = r_out_mag;
    out_dir    = r_out_dir;
    w_take     = r_cand_vld && (r_cand_mag > r_best_mag);
    w_best_mag = w_take ? r_cand_mag : r_best_mag;
    w_best_dir = w_take ? r_cand_dir : r_best_dir;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (in_valid) w_state_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == CNT_LAST) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = in_valid ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, window latch, candidate register and max tracker.
  // The direction result is registered before the compare, so RUN spends one
  // extra cycle (cnt==8) merging direction 7 and loading the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pix      <= '0;
      r_mask     <= '0;
      r_cnt      <= '0;
      r_cand_mag <= '0;
      r_cand_dir <= '0;
      r_cand_vld <= 1'b0;
      r_best_mag <= '0;
      r_best_dir <= '0;
      r_out_mag  <= '0;
      r_out_dir  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pix      <= {p9, p8, p7, p6, p4, p3, p2, p1};
        r_mask     <= cfg_dir_mask;
        r_cnt      <= '0;
        r_cand_vld <= 1'b0;
        r_best_mag <= '0;
        r_best_dir <= '0;
      end else if (r_state == ST_RUN) begin
        r_cand_mag <= w_dir_mag;
        r_cand_dir <= r_cnt[2:0];
        r_cand_vld <= (r_cnt < CNT_LAST) && r_mask[r_cnt[2:0]];
        r_best_mag <= w_best_mag;
        r_best_dir <= w_best_dir;
        if (r_cnt != CNT_LAST)
          r_cnt <= r_cnt + 4'd1;
        else begin
          r_out_mag <= w_best_mag;
          r_out_dir <= w_best_dir;
        end
      end
    end
  end

endmodule

// File: tb/tb_kirsch_compass_seq.sv
// Self-checking bench for kirsch_compass_seq against a behavioural model.
module tb_kirsch_compass_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] p1, p2, p3, p4, p6, p7, p8, p9;
  logic [7:0] cfg_dir_mask;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_mag;
  logic [2:0] out_dir;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  kirsch_compass_seq #(.PIX_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .p1           (p1),
    .p2           (p2),
    .p3           (p3),
    .p4           (p4),
    .p6           (p6),
    .p7           (p7),
    .p8           (p8),
    .p9           (p9),
    .cfg_dir_mask (cfg_dir_mask),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_mag      (out_mag),
    .out_dir      (out_dir),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference: raster window w[1..9], weight +5 on ring k..k+2, -3 elsewhere.
  function automatic void model(input logic [7:0] w [10], input logic [7:0] m,
                                output logic [7:0] mag, output logic [2:0] dir);
    int ring [8];
    int best;
    int bd;
    ring = '{1, 2, 3, 6, 9, 8, 7, 4};
    best = 0;
    bd   = 0;
    for (int k = 0; k < 8; k++) begin
      int r;
      int c;
      r = 0;
      for (int i = 0; i < 8; i++) begin
        if (((i - k + 8) % 8) < 3) r += 5 * int'(w[ring[i]]);
        else                       r -= 3 * int'(w[ring[i]]);
      end
      c = (r < 0) ? 0 : ((r > 255) ? 255 : r);
      if (m[k] && c > best) begin
        best = c;
        bd   = k;
      end
    end
    mag = 8'(best);
    dir = 3'(bd);
  endfunction

  task automatic drive_pins(input logic [7:0] w [10]);
    p1 = w[1]; p2 = w[2]; p3 = w[3]; p4 = w[4];
    p6 = w[6]; p7 = w[7]; p8 = w[8]; p9 = w[9];
  endtask

  task automatic scramble_pins();
    p1 = 8'($urandom); p2 = 8'($urandom); p3 = 8'($urandom); p4 = 8'($urandom);
    p6 = 8'($urandom); p7 = 8'($urandom); p8 = 8'($urandom); p9 = 8'($urandom);
    cfg_dir_mask = 8'($urandom);
  endtask

  // Present a window once in_ready is seen, then hold it for the accept edge.
  task automatic accept_window(input logic [7:0] w [10], input logic [7:0] m, input string name);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready got=%b want=1", name, in_ready);
    end
    drive_pins(w);
    cfg_dir_mask = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_pins();
  endtask

  // From just after the accept edge, wait for out_valid and check the result.
  task automatic expect_result(input logic [7:0] w [10], input logic [7:0] m, input string name);
    logic [7:0] em;
    logic [2:0] ed;
    int lat;
    bit busy_bad;
    model(w, m, em, ed);
    lat = 0;
    busy_bad = 0;
    while (lat < 20) begin
      if (busy !== 1'b1) busy_bad = 1;
      @(posedge clk); #1;
      lat++;
      if (out_valid === 1'b1) break;
    end
    checks++;
    if (lat != 9 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_latency got=%0d want=9", name, lat);
    end
    checks++;
    if (busy_bad || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy got_bad=%0d busy=%b want busy high in RUN, low in DONE", name, busy_bad, busy);
    end
    checks++;
    if (out_mag !== em) begin
      failures++;
      $display("FAIL %s_mag got=%0d want=%0d", name, out_mag, em);
    end
    checks++;
    if (out_dir !== ed) begin
      failures++;
      $display("FAIL %s_dir got=%0d want=%0d", name, out_dir, ed);
    end
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_in_ready_done got=%b want=1", name, in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_valid_drop got=%b want=0", name, out_valid);
    end
  endtask

  task automatic run_one(input logic [7:0] w [10], input logic [7:0] m, input string name);
    accept_window(w, m, name);
    expect_result(w, m, name);
    release_result(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, out_mag, out_dir} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b mag=%0d dir=%0d want all 0",
               in_ready, out_valid, busy, out_mag, out_dir);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_flat();
    logic [7:0] w [10];
    foreach (w[i]) w[i] = 8'd100;
    run_one(w, 8'hFF, "flat");
  endtask

  task automatic test_top_row();
    logic [7:0] w [10];
    foreach (w[i]) w[i] = 8'd0;
    w[1] = 8'd255; w[2] = 8'd255; w[3] = 8'd255;
    run_one(w, 8'hFF, "top_row");
  endtask

  task automatic test_tie_mask();
    logic [7:0] w [10];
    foreach (w[i]) w[i] = 8'd0;
    w[3] = 8'd10; w[6] = 8'd10; w[9] = 8'd10;
    run_one(w, 8'hFF, "east");
    run_one(w, 8'hFB, "tie");
  endtask

  task automatic test_mask_zero();
    logic [7:0] w [10];
    foreach (w[i]) w[i] = 8'($urandom);
    w[1] = 8'd255; w[2] = 8'd255; w[3] = 8'd255;
    run_one(w, 8'h00, "mask0");
  endtask

  task automatic test_random();
    logic [7:0] w [10];
    for (int n = 0; n < 24; n++) begin
      foreach (w[i]) w[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255))
                                                         : 8'($urandom_range(0, 60));
      run_one(w, (n % 4 == 0) ? 8'hFF : 8'($urandom), "random");
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] w [10];
    logic [7:0] w2 [10];
    logic [7:0] m2;
    logic [7:0] hm;
    logic [2:0] hd;
    foreach (w[i]) w[i] = 8'($urandom);
    foreach (w2[i]) w2[i] = 8'($urandom_range(0, 90));
    w2[7] = 8'd240; w2[4] = 8'd230; w2[1] = 8'd220;
    m2 = 8'hFF;
    accept_window(w, 8'hFF, "bp");
    expect_result(w, 8'hFF, "bp");
    hm = out_mag;
    hd = out_dir;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      drive_pins(w2);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_mag !== hm || out_dir !== hd) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got vld=%b rdy=%b mag=%0d dir=%0d want vld=1 rdy=0 mag=%0d dir=%0d",
                 c, out_valid, in_ready, out_mag, out_dir, hm, hd);
      end
      @(posedge clk); #1;
    end
    drive_pins(w2);
    cfg_dir_mask = m2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_same_cycle_accept got=%b want=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    scramble_pins();
    expect_result(w2, m2, "bp_next");
    release_result("bp_next");
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] w [10];
    int seen;
    foreach (w[i]) w[i] = 8'd0;
    w[1] = 8'd255; w[2] = 8'd255; w[3] = 8'd255;
    accept_window(w, 8'hFF, "mid_rst");
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, busy, out_mag, out_dir} !== 13'd0) begin
      failures++;
      $display("FAIL mid_rst_outputs got rdy=%b vld=%b busy=%b mag=%0d dir=%0d want all 0",
               in_ready, out_valid, busy, out_mag, out_dir);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_idle got rdy=%b busy=%b want rdy=1 busy=0", in_ready, busy);
    end
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL mid_rst_no_result got=%0d valid cycles want=0", seen);
    end
    foreach (w[i]) w[i] = 8'd0;
    w[3] = 8'd10; w[6] = 8'd10; w[9] = 8'd10;
    run_one(w, 8'hFF, "post_rst");
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    cfg_dir_mask = 8'h00;
    {p1, p2, p3, p4, p6, p7, p8, p9} = '0;
    @(posedge clk); #1;
    test_reset();
    test_flat();
    test_top_row();
    test_tie_mask();
    test_mask_zero();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
